wb_bus_arbiter: RTL
===================

WB_BUS_ARBITER -- requirements
Module: wb_bus_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 32, SHALL set the acked transfers a master may complete while the other master is requesting before it is preempted (range 1..255).
REQ-002 Parameter TIMEOUT, default 255, SHALL set the granted cycles without ack/err/rty before the arbiter aborts the cycle (range 2..1023).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL change on posedge clk.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 m0  wishbone_b3.slave  bundle  SHALL connect the display DMA master (high priority).
REQ-006 m1  wishbone_b3.slave  bundle  SHALL connect the CPU master (low priority).
REQ-007 s  wishbone_b3.master  bundle  SHALL connect the shared memory slave (frame buffer, base 0x01000000).
REQ-008 grant  output  2  SHALL be one-hot owner indication: 01 = m0, 10 = m1, 00 = none.

Function
REQ-009 The FSM SHALL have exactly three states: IDLE, GRANT0 and GRANT1.
REQ-010 A master SHALL count as requesting when its cyc and stb are both 1.
REQ-011 IDLE transitions:
- only m0 requesting -> GRANT0; only m1 requesting -> GRANT1.
- both requesting -> GRANT0, unless flag yield0 is set, in which case -> GRANT1.
- neither requesting -> stay in IDLE.
REQ-012 On entering a GRANTx state, s.cyc/s.stb SHALL be asserted in the first cycle the state is GRANTx; request-to-grant latency SHALL be 1 clock.
REQ-013 In GRANTx, s.adr, s.dat_m2s, s.we, s.sel, s.cti, s.bte, s.cyc and s.stb SHALL be combinationally forwarded from mx.
REQ-014 In IDLE, s.cyc, s.stb and s.we SHALL be 0 and s.adr, s.dat_m2s, s.sel, s.cti, s.bte SHALL be 0.
REQ-015 s.ack, s.err and s.rty SHALL be forwarded only to the granted master; the non-granted master SHALL see ack = err = rty = 0.
REQ-016 s.dat_s2m SHALL be broadcast to both masters unconditionally.
REQ-017 GRANTx SHALL return to IDLE on the cycle after mx.cyc is sampled 0 (master release).
REQ-018 burst_cnt (8 bit) SHALL clear on grant entry and increment on each s.ack in GRANTx, saturating at 255.
REQ-019 Preemption: when s.ack occurs with burst_cnt == MAX_BURST-1 and the other master is requesting, GRANTx SHALL go to IDLE on the next clock and set yieldx.
REQ-020 A preempted master SHALL keep its cyc asserted; it SHALL see no response until re-granted (legal wait states).
REQ-021 yield0 SHALL clear when GRANT1 is entered; yield1 SHALL be ignored in IDLE (m0 priority) and clear when GRANT0 is entered.
REQ-022 Every GRANTx to GRANTy change SHALL pass through exactly one IDLE cycle with s.cyc = 0.
REQ-023 wait_cnt (10 bit) SHALL clear on grant entry and on any ack/err/rty, and otherwise increment each GRANTx cycle.
REQ-024 When wait_cnt reaches TIMEOUT-1:
- the arbiter SHALL assert err to mx for exactly one cycle;
- s.cyc/s.stb SHALL be forced to 0 that cycle;
- the FSM SHALL go to IDLE.
REQ-025 If slave err or rty occurs in GRANTx, it SHALL be forwarded and the grant SHALL be kept until mx releases cyc.
REQ-026 Release and preemption in the same cycle SHALL resolve as release; the yield flag SHALL NOT be set.
REQ-027 The arbiter SHALL never assert ack and err together to one master.

Reset
REQ-028 With rst = 1 at a clock edge:
- state SHALL be IDLE and grant SHALL be 00;
- burst_cnt, wait_cnt, yield0 and yield1 SHALL be 0;
- s.cyc and s.stb SHALL be 0.
REQ-029 Reset mid-transfer SHALL abort the cycle silently, with no err issued to the master.
REQ-030 The first grant after rst deasserts SHALL follow the REQ-011 rules.

Verification
REQ-031 m1 alone requests 4 single reads; slave acks each after 2 wait states:
- grant SHALL be 10 one clock after request;
- m1 SHALL receive 4 acks with the slave data;
- m0 SHALL receive no ack.
REQ-032 m0 and m1 request in the same cycle from IDLE -> grant SHALL be 01 first.
REQ-033 MAX_BURST = 4; m0 holds a 10-beat burst while m1 requests:
- after the 4th ack, one IDLE cycle with s.cyc = 0 SHALL follow, then grant = 10;
- when m1 finishes, m0 SHALL resume.
REQ-034 TIMEOUT = 8; slave never responds to m1:
- m1 SHALL get err in the 8th granted cycle;
- grant SHALL be 00 on the next clock.
REQ-035 rst is asserted during the 3rd beat of an m0 burst:
- the next cycle SHALL show grant = 00 and s.cyc = 0;
- m0 SHALL see no err.

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// Purpose : two-master Wishbone B3 arbiter, m0 (display DMA) over m1 (CPU), onto one memory slave.
// Latency : request to grant is one clock; the granted master's bus is forwarded combinationally.
// Backpres: a waiting master keeps cyc/stb up and sees no response until it is granted.
//
// Ports:
//   clk, rst                  single clock, synchronous active-high reset
//   m0_* / m1_*               Wishbone slave-side bundles: cyc, stb, we, adr, dat_m2s, sel, cti, bte in;
//                             dat_s2m, ack, err, rty out
//   s_*                       Wishbone master-side bundle toward the shared frame-buffer memory
//   grant                     owner indication: 01 = m0, 10 = m1, 00 = none
module wb_bus_arbiter #(
  parameter int MAX_BURST = 32,   // acked beats allowed while the other master waits (1..255)
  parameter int TIMEOUT   = 255   // granted cycles without a response before abort (2..1023)
) (
  input  logic        clk,
  input  logic        rst,
  // m0: display DMA, high priority
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [31:0] m0_adr,
  input  logic [31:0] m0_dat_m2s,
  input  logic [3:0]  m0_sel,
  input  logic [2:0]  m0_cti,
  input  logic [1:0]  m0_bte,
  output logic [31:0] m0_dat_s2m,
  output logic        m0_ack,
  output logic        m0_err,
  output logic        m0_rty,
  // m1: CPU, low priority
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [31:0] m1_adr,
  input  logic [31:0] m1_dat_m2s,
  input  logic [3:0]  m1_sel,
  input  logic [2:0]  m1_cti,
  input  logic [1:0]  m1_bte,
  output logic [31:0] m1_dat_s2m,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        m1_rty,
  // s: shared memory slave
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [31:0] s_adr,
  output logic [31:0] s_dat_m2s,
  output logic [3:0]  s_sel,
  output logic [2:0]  s_cti,
  output logic [1:0]  s_bte,
  input  logic [31:0] s_dat_s2m,
  input  logic        s_ack,
  input  logic        s_err,
  input  logic        s_rty,
  // ownership
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_t;

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [9:0] WAIT_LAST  = 10'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  burst_cnt;
  logic [9:0]  wait_cnt;
  logic        yield0, yield1;

  logic        req0, req1, own1, cur_cyc, other_req, timeout;
  logic        fwd_ack, fwd_err, fwd_rty, preempt;

  assign req0      = m0_cyc & m0_stb;
  assign req1      = m1_cyc & m1_stb;
  assign own1      = (state == GRANT1);
  assign cur_cyc   = own1 ? m1_cyc : m0_cyc;
  assign other_req = own1 ? req0 : req1;
  // Abort only a live cycle; a master that already dropped cyc is simply released.
  assign timeout   = (state != IDLE) && cur_cyc && (wait_cnt == WAIT_LAST);

  // Read data carries no ownership, so both masters always see it.
  assign m0_dat_s2m = s_dat_s2m;
  assign m1_dat_s2m = s_dat_s2m;

  always_comb begin
    state_nxt = state;
    grant     = 2'b00;
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    s_we      = 1'b0;
    s_adr     = '0;
    s_dat_m2s = '0;
    s_sel     = '0;
    s_cti     = '0;
    s_bte     = '0;
    fwd_ack   = 1'b0;
    fwd_err   = 1'b0;
    fwd_rty   = 1'b0;
    preempt   = 1'b0;

    case (state)
      IDLE: begin
        // yield1 never overrides m0 priority; the two flags are never set together,
        // so the extra term only makes that explicit.
        if (req0 && !(req1 && yield0 && !yield1)) state_nxt = GRANT0;
        else if (req1)                             state_nxt = GRANT1;
      end

      GRANT0, GRANT1: begin
        grant = own1 ? 2'b10 : 2'b01;
        // On the abort cycle the slave is detached so it cannot act on a stale strobe.
        if (!timeout) begin
          s_cyc     = own1 ? m1_cyc     : m0_cyc;
          s_stb     = own1 ? m1_stb     : m0_stb;
          s_we      = own1 ? m1_we      : m0_we;
          s_adr     = own1 ? m1_adr     : m0_adr;
          s_dat_m2s = own1 ? m1_dat_m2s : m0_dat_m2s;
          s_sel     = own1 ? m1_sel     : m0_sel;
          s_cti     = own1 ? m1_cti     : m0_cti;
          s_bte     = own1 ? m1_bte     : m0_bte;
        end
        // err wins over ack so a master never sees both in one cycle.
        fwd_ack = !timeout && s_ack && !s_err;
        fwd_err = timeout || s_err;
        fwd_rty = !timeout && s_rty;

        // Release is checked first so release-with-preemption never sets a yield flag.
        if (!cur_cyc) begin
          state_nxt = IDLE;
        end else if (timeout) begin
          state_nxt = IDLE;
        end else if (fwd_ack && (burst_cnt >= BURST_LAST) && other_req) begin
          state_nxt = IDLE;
          preempt   = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase

    m0_ack = fwd_ack & ~own1;
    m0_err = fwd_err & ~own1;
    m0_rty = fwd_rty & ~own1;
    m1_ack = fwd_ack &  own1;
    m1_err = fwd_err &  own1;
    m1_rty = fwd_rty &  own1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
      wait_cnt  <= '0;
      yield0    <= 1'b0;
      yield1    <= 1'b0;
    end else begin
      state <= state_nxt;

      // Every grant is entered from IDLE, so clearing here covers grant entry.
      if (state == IDLE) begin
        burst_cnt <= '0;
        wait_cnt  <= '0;
      end else begin
        if (fwd_ack && (burst_cnt != 8'hFF)) burst_cnt <= burst_cnt + 8'd1;
        if (fwd_ack || fwd_err || fwd_rty)   wait_cnt  <= '0;
        else                                 wait_cnt  <= wait_cnt + 10'd1;
      end

      if (preempt) begin
        if (own1) yield1 <= 1'b1;
        else      yield0 <= 1'b1;
      end
      if (state == IDLE && state_nxt == GRANT1) yield0 <= 1'b0;
      if (state == IDLE && state_nxt == GRANT0) yield1 <= 1'b0;
    end
  end

endmodule
